// File: rtl/demux_1to2_buf.sv
// Registered 1-to-2 demultiplexer with valid/ready handshaking.
// Each output has a one-entry holding register and a wrapping transfer counter.
module demux_1to2_buf #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sel,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout_0,
    output logic             dout_0_valid,
    input  logic             dout_0_ready,
    output logic [WIDTH-1:0] dout_1,
    output logic             dout_1_valid,
    input  logic             dout_1_ready,
    output logic [CW-1:0]    count_0,
    output logic [CW-1:0]    count_1
);

    logic acc;
    logic load_0;
    logic load_1;
    logic drn_0;
    logic drn_1;

    // Ready looks only at the addressed buffer; a draining buffer can take a new word.
    always_comb begin
        din_ready = 1'b0;
        if (sel) begin
            din_ready = !dout_1_valid || dout_1_ready;
        end else begin
            din_ready = !dout_0_valid || dout_0_ready;
        end
    end

    assign acc    = din_valid && din_ready;
    assign load_0 = acc && !sel;
    assign load_1 = acc && sel;
    assign drn_0  = dout_0_valid && dout_0_ready;
    assign drn_1  = dout_1_valid && dout_1_ready;

    // Output 0 buffer: a load wins over a same-cycle drain.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dout_0       <= '0;
            dout_0_valid <= 1'b0;
        end else if (load_0) begin
            dout_0       <= din;
            dout_0_valid <= 1'b1;
        end else if (drn_0) begin
            dout_0_valid <= 1'b0;
        end
    end

    // Output 1 buffer: a load wins over a same-cycle drain.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dout_1       <= '0;
            dout_1_valid <= 1'b0;
        end else if (load_1) begin
            dout_1       <= din;
            dout_1_valid <= 1'b1;
        end else if (drn_1) begin
            dout_1_valid <= 1'b0;
        end
    end

    // Completed-transfer counters, wrapping without saturation.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_0 <= '0;
            count_1 <= '0;
        end else begin
            if (drn_0) begin
                count_0 <= count_0 + CW'(1);
            end
            if (drn_1) begin
                count_1 <= count_1 + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_demux_1to2_buf.sv
// Scoreboard bench for demux_1to2_buf: directed scenarios plus randomized traffic
// checked against per-output FIFO models.
module tb_demux_1to2_buf;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CW    = 8;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             sel = 1'b0;
    logic             din_ready;
    logic [WIDTH-1:0] dout_0;
    logic             dout_0_valid;
    logic             dout_0_ready = 1'b0;
    logic [WIDTH-1:0] dout_1;
    logic             dout_1_valid;
    logic             dout_1_ready = 1'b0;
    logic [CW-1:0]    count_0;
    logic [CW-1:0]    count_1;

    demux_1to2_buf #(.WIDTH(WIDTH), .CW(CW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .din(din), .din_valid(din_valid), .sel(sel), .din_ready(din_ready),
        .dout_0(dout_0), .dout_0_valid(dout_0_valid), .dout_0_ready(dout_0_ready),
        .dout_1(dout_1), .dout_1_valid(dout_1_valid), .dout_1_ready(dout_1_ready),
        .count_0(count_0), .count_1(count_1)
    );

    always #5 CLK = ~CLK;

    // Words accepted but not yet delivered, per output, and expected drain counts.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int unsigned      mc0 = 0;
    int unsigned      mc1 = 0;
    int               n_vec = 0;
    int               n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares the DUT against the queue models, then retires drains.
    initial begin
        logic exp_rdy;
        forever begin
            @(negedge CLK);
            chk("valid0", 32'(dout_0_valid), 32'(q0.size() != 0));
            chk("valid1", 32'(dout_1_valid), 32'(q1.size() != 0));
            if (q0.size() != 0) chk("data0", 32'(dout_0), 32'(q0[0]));
            if (q1.size() != 0) chk("data1", 32'(dout_1), 32'(q1[0]));
            exp_rdy = sel ? (q1.size() == 0 || dout_1_ready) : (q0.size() == 0 || dout_0_ready);
            chk("din_ready", 32'(din_ready), 32'(exp_rdy));
            chk("count0", 32'(count_0), mc0 % (1 << CW));
            chk("count1", 32'(count_1), mc1 % (1 << CW));
            if (q0.size() != 0 && dout_0_ready) begin
                void'(q0.pop_front());
                mc0++;
            end
            if (q1.size() != 0 && dout_1_ready) begin
                void'(q1.pop_front());
                mc1++;
            end
        end
    end

    // One clock cycle of stimulus; records the accepted word in the scoreboard.
    task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d,
                        input logic r0, input logic r1, output logic acc);
        @(posedge CLK);
        #1;
        din_valid    = v;
        sel          = s;
        din          = d;
        dout_0_ready = r0;
        dout_1_ready = r1;
        @(negedge CLK);
        #2;
        acc = din_valid && din_ready;
        if (acc) begin
            if (sel) q1.push_back(din);
            else     q0.push_back(din);
        end
    endtask

    task automatic idle(input logic r0, input logic r1);
        logic a;
        step(1'b0, 1'b0, '0, r0, r1, a);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_v0"}, 32'(dout_0_valid), 0);
        chk({tag, "_v1"}, 32'(dout_1_valid), 0);
        chk({tag, "_d0"}, 32'(dout_0), 0);
        chk({tag, "_d1"}, 32'(dout_1), 0);
        chk({tag, "_c0"}, 32'(count_0), 0);
        chk({tag, "_c1"}, 32'(count_1), 0);
    endtask

    task automatic apply_reset();
        din_valid = 1'b0;
        RST_N     = 1'b0;
        #1;
        check_reset_values("async_rst");
        q0.delete();
        q1.delete();
        mc0 = 0;
        mc1 = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    initial begin
        logic             acc;
        logic             pend;
        logic             ps;
        logic [WIDTH-1:0] pw;
        int unsigned      age;
        int unsigned      b0;
        int unsigned      b1;

        // Power-on reset.
        repeat (2) @(negedge CLK);
        check_reset_values("por");
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Basic steer to output 0.
        step(1'b1, 1'b0, 16'hA5A5, 1'b1, 1'b1, acc);
        chk("steer_acc", 32'(acc), 1);
        idle(1'b1, 1'b1);
        chk("steer_v0", 32'(dout_0_valid), 1);
        chk("steer_d0", 32'(dout_0), 32'h0000_A5A5);
        chk("steer_v1", 32'(dout_1_valid), 0);
        idle(1'b1, 1'b1);
        chk("steer_v0_off", 32'(dout_0_valid), 0);
        chk("steer_cnt0", 32'(count_0), 1);

        // Backpressure on output 1, then pass-through on drain.
        step(1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, acc);
        chk("bp_acc1", 32'(acc), 1);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, acc);
            chk("bp_stall", 32'(acc), 0);
            chk("bp_hold", 32'(dout_1), 32'h0001);
        end
        step(1'b1, 1'b1, 16'h0002, 1'b1, 1'b1, acc);
        chk("bp_pass", 32'(acc), 1);
        idle(1'b1, 1'b1);
        chk("bp_d1", 32'(dout_1), 32'h0002);
        chk("bp_v1", 32'(dout_1_valid), 1);
        idle(1'b1, 1'b1);
        chk("bp_cnt1", 32'(count_1), 2);

        // Stalled output 1 does not block output 0.
        step(1'b1, 1'b1, 16'h0003, 1'b1, 1'b0, acc);
        step(1'b1, 1'b0, 16'h00FF, 1'b1, 1'b0, acc);
        chk("ind_acc", 32'(acc), 1);
        idle(1'b1, 1'b0);
        chk("ind_d0", 32'(dout_0), 32'h00FF);
        chk("ind_d1", 32'(dout_1), 32'h0003);
        chk("ind_v1", 32'(dout_1_valid), 1);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // Back-to-back streaming alternating between outputs.
        b0 = mc0;
        b1 = mc1;
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'(i), WIDTH'(i), 1'b1, 1'b1, acc);
            chk("stream_gap", 32'(acc), 1);
        end
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        chk("stream_cnt0", 32'(count_0), (b0 + 128) % (1 << CW));
        chk("stream_cnt1", 32'(count_1), (b1 + 128) % (1 << CW));

        // Asynchronous reset with both buffers full.
        step(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, acc);
        step(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, acc);
        idle(1'b0, 1'b0);
        chk("pre_rst_v0", 32'(dout_0_valid), 1);
        chk("pre_rst_v1", 32'(dout_1_valid), 1);
        apply_reset();

        // Counter wrap on output 0.
        for (int i = 0; i < 255; i++) step(1'b1, 1'b0, WIDTH'(i), 1'b1, 1'b1, acc);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        chk("wrap_255", 32'(count_0), 255);
        step(1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b1, acc);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        chk("wrap_0", 32'(count_0), 0);
        step(1'b1, 1'b0, 16'hCAFE, 1'b1, 1'b1, acc);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        chk("wrap_1", 32'(count_0), 1);

        // Randomized traffic; the source holds a word until it is accepted.
        pend = 1'b0;
        ps   = 1'b0;
        pw   = '0;
        age  = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                pw   = WIDTH'($urandom);
                ps   = 1'($urandom_range(0, 1));
                age  = 0;
            end
            step(pend, pend ? ps : 1'($urandom_range(0, 1)), pend ? pw : WIDTH'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, acc);
            if (acc) begin
                pend = 1'b0;
            end else if (pend) begin
                age++;
                if (age > 100) begin
                    chk("accept_timeout", 32'(age), 0);
                    pend = 1'b0;
                end
            end
        end
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/demux_1to2_buf.md
# demux_1to2_buf

Registered 1-to-2 demultiplexer with valid/ready handshaking: steers a single WIDTH-bit source stream to one of two destinations under `sel`, with a one-entry holding register per destination. It is the return path for the datapath's 2:1 input selection. One source fans out to two consumers, such as the accumulator writeback and the memory-write port. The consumers may stall independently. Per-output transfer counters are provided for debug and verification.

## Interface
Parameters:
- `WIDTH`, default 16: data width.
- `CW`, default 8: transfer counter width.

Ports:
- `CLK` in, 1: single clock; all state updates on rising edge.
- `RST_N` in, 1: reset, asynchronous and active-low.
- `din` in, WIDTH: source data.
- `din_valid` in, 1: source offers `din`.
- `sel` in, 1: destination of the offered word (0 → out 0, 1 → out 1); sampled with `din`.
- `din_ready` out, 1: block accepts the offered word this cycle.
- `dout_0` out, WIDTH: buffered word for destination 0.
- `dout_0_valid` out, 1: buffer 0 holds a word.
- `dout_0_ready` in, 1: destination 0 takes the word.
- `dout_1` out, WIDTH: buffered word for destination 1.
- `dout_1_valid` out, 1: buffer 1 holds a word.
- `dout_1_ready` in, 1: destination 1 takes the word.
- `count_0` out, CW: completed transfers on output 0.
- `count_1` out, CW: completed transfers on output 1.

## Operation
- Buffer state: each output x has a full flag `dout_x_valid` and a data register `dout_x`. Together these form a two-state machine per output, EMPTY ↔ FULL.
- Accept: `acc = din_valid & din_ready`.
- Drain: `drn_x = dout_x_valid & dout_x_ready`.
- `din_ready` (combinational) = `!dout_sel_valid | dout_sel_ready`, evaluated on the buffer addressed by the current `sel`. Pass-through-on-drain is required.
- `din_ready` is independent of `din_valid`.
- `din_ready` never depends on the non-selected buffer.
- Buffer x update each cycle:
  - `acc & sel==x`: load `dout_x <= din`, set valid to 1. This holds whether or not `drn_x` occurs the same cycle, so a simultaneous drain+load stays FULL with new data.
  - Else `drn_x`: valid goes to 0; `dout_x` keeps its old value.
  - Else: hold.
- The two buffers operate independently. Output 1 may drain in the same cycle that output 0 loads, and vice versa.
- Ordering: each output delivers its words in acceptance order. No ordering is defined between outputs.
- Counters: `count_x` increments by 1 on each `drn_x` and wraps modulo 2^CW (255 → 0 at CW=8). There is no saturation.
- `sel` and `din` are ignored when `!din_valid`.
- Data is never dropped or duplicated.
- Reset (RST_N low, any time, asynchronous):
  - Both valids go to 0.
  - `dout_0`, `dout_1`, `count_0`, `count_1` go to 0.
  - Any in-flight word is discarded.
  - Outputs are held in these values while RST_N is low. Normal operation resumes on the first rising CLK edge after deassertion.

## Timing
- Latency: a word accepted at edge N appears on `dout_x`/`dout_x_valid` immediately after edge N (1 cycle). It is drainable in the cycle following N.
- Throughput: 1 word/cycle sustained to either output, or alternating between outputs, while the addressed consumer holds ready high.
- `din_ready` is combinational from `sel`, `dout_x_valid`, `dout_x_ready`.
- All other outputs are registered.
- Counter values reflect drains completed at or before the most recent edge.
- Source rule: once `din_valid` is high with a given `din`/`sel`, the source holds them until accepted. The block does not check this.

## Test plan
- Reset: assert RST_N=0 mid-stream with both buffers FULL → both valids 0, `dout_*`=0, counters 0 asynchronously, before the next CLK edge.
- Basic steer: `din`=16'hA5A5, sel=0, valid 1 cycle, consumers ready → `dout_0_valid` high for 1 cycle with 16'hA5A5, `dout_1_valid` stays 0, `count_0`=1.
- Backpressure and pass-through:
  - Setup: `dout_1_ready`=0, send 16'h0001 then 16'h0002 to sel=1 → second word stalls (`din_ready`=0) while buffer 1 holds 16'h0001.
  - Raise `dout_1_ready` → same edge drains 0001 and loads 0002, valid stays 1; next cycle 0002 is delivered, `count_1`=2.
- Independence: buffer 1 FULL and stalled; send 16'h00FF with sel=0 → `din_ready`=1, word lands in buffer 0 next cycle, buffer 1 unchanged.
- Streaming: 256 back-to-back words 0..255 alternating sel, both consumers ready → each output receives its 128 words in order, no gaps, `count_0`=`count_1`=128.
- Counter wrap: 256 drains on output 0 → `count_0` goes 255 → 0; a 257th drain gives 1.
